// File: rtl/ext_arbiter.sv
// Shared 16->32 bit extension unit: two requesters, round-robin arbitration, one-entry output register.
// Optional feature: define EXT_BYTE_EN to enable the sign8/zero8 byte modes (10/11).
module ext_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic [15:0] In0,
    input  logic [1:0]  Mode0,
    output logic        Gnt0,
    input  logic        Req1,
    input  logic [15:0] In1,
    input  logic [1:0]  Mode1,
    output logic        Gnt1,
    output logic        OutValid,
    output logic [31:0] OutData,
    output logic        OutId,
    input  logic        OutReady
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        id_q, id_d;
    logic        last_q, last_d;

    logic        accept;
    logic        pick;
    logic [15:0] selIn;
    logic [1:0]  selMode;
    logic [31:0] extData;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        pick = 1'b0;
        if (Req0 && Req1) begin
            pick = ~last_q;
        end else if (Req1) begin
            pick = 1'b1;
        end
        accept = (~valid_q | OutReady) & (Req0 | Req1);
        Gnt0   = Reset & accept & ~pick;
        Gnt1   = Reset & accept & pick;
    end

    always_comb begin
        selIn   = pick ? In1 : In0;
        selMode = pick ? Mode1 : Mode0;
        extData = {16'h0, selIn};
`ifdef EXT_BYTE_EN
        case (selMode)
            2'b00:   extData = {{16{selIn[15]}}, selIn};
            2'b01:   extData = {16'h0, selIn};
            2'b10:   extData = {{24{selIn[7]}}, selIn[7:0]};
            default: extData = {24'h0, selIn[7:0]};
        endcase
`else
        if (!selMode[0]) begin
            extData = {{16{selIn[15]}}, selIn};
        end
`endif
    end

`ifndef EXT_BYTE_EN
    // Without byte modes the upper mode bit carries no meaning.
    logic unused_modeHi;
    assign unused_modeHi = selMode[1];
`endif

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = extData;
            id_d    = pick;
            last_d  = pick;
        end else if (valid_q && OutReady) begin
            valid_d = 1'b0;
        end
    end

    // Last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign OutValid = valid_q;
    assign OutData  = data_q;
    assign OutId    = id_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: directed scenarios plus a randomized run against a behavioural model.
// Honours EXT_BYTE_EN the same way the design does.
module tb_ext_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0, OutReady = 1'b0;
    logic [15:0] In0 = 16'h0, In1 = 16'h0;
    logic [1:0]  Mode0 = 2'b0, Mode1 = 2'b0;
    logic        Gnt0, Gnt1, OutValid, OutId;
    logic [31:0] OutData;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model of the visible state
    bit          mValid;
    bit          mId;
    bit          mLast = 1'b1;
    logic [31:0] mData;

    ext_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .In0(In0), .Mode0(Mode0), .Gnt0(Gnt0),
        .Req1(Req1), .In1(In1), .Mode1(Mode1), .Gnt1(Gnt1),
        .OutValid(OutValid), .OutData(OutData), .OutId(OutId), .OutReady(OutReady)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] extModel(logic [15:0] v, logic [1:0] m);
        logic [7:0] b;
        b = v[7:0];
`ifdef EXT_BYTE_EN
        if (m == 2'd2) return 32'($signed(b));
        if (m == 2'd3) return 32'(b);
`endif
        if (m[0]) return 32'(v);
        return 32'($signed(v));
    endfunction

    function automatic int modelPick();
        if (Req0 && Req1) return mLast ? 0 : 1;
        return Req1 ? 1 : 0;
    endfunction

    function automatic bit modelAccept();
        return Reset && (!mValid || OutReady) && (Req0 || Req1);
    endfunction

    function automatic logic [1:0] modelGrants();
        if (!modelAccept()) return 2'b00;
        return (modelPick() == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic modelReset();
        mValid = 1'b0;
        mData  = 32'h0;
        mId    = 1'b0;
        mLast  = 1'b1;
    endtask

    // Clock one edge and move the model by the same rules.
    task automatic advance();
        bit          acc;
        bit          rdy;
        int          p;
        logic [31:0] e;
        acc = modelAccept();
        rdy = OutReady;
        p   = modelPick();
        e   = (p == 1) ? extModel(In1, Mode1) : extModel(In0, Mode0);
        @(posedge Clk); #1;
        if (acc) begin
            mData  = e;
            mId    = (p == 1);
            mValid = 1'b1;
            mLast  = (p == 1);
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
    endtask

    task automatic doReset();
        Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0; OutReady = 1'b0;
        modelReset();
        @(posedge Clk); #1;
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        Reset = 1'b0; Req0 = 1'b1; In0 = 16'h1234; Mode0 = 2'b00; OutReady = 1'b1;
        modelReset();
        #2;
        nChecks++; if (OutValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", OutValid); end
        nChecks++; if (OutData !== 32'h0) begin nFails++; $display("[TB] FAIL reset_data: got %h want 00000000", OutData); end
        nChecks++; if (OutId !== 1'b0) begin nFails++; $display("[TB] FAIL reset_id: got %b want 0", OutId); end
        nChecks++; if (Gnt0 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_gnt0: got %b want 0", Gnt0); end
        @(posedge Clk); #1;
        nChecks++; if (OutValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_hold_valid: got %b want 0", OutValid); end
        Reset = 1'b1;
        #1;
        nChecks++; if (Gnt0 !== 1'b1) begin nFails++; $display("[TB] FAIL release_gnt0: got %b want 1", Gnt0); end
        advance();
        nChecks++; if (OutValid !== 1'b1) begin nFails++; $display("[TB] FAIL release_valid: got %b want 1", OutValid); end
        nChecks++; if (OutData !== 32'h00001234) begin nFails++; $display("[TB] FAIL release_data: got %h want 00001234", OutData); end
        Req0 = 1'b0;
    endtask

    task automatic test_modes();
        logic [15:0] ins [4];
        logic [31:0] exps [4];
        ins  = '{16'h8001, 16'h8001, 16'h1280, 16'h1280};
`ifdef EXT_BYTE_EN
        exps = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFF80, 32'h00000080};
`else
        exps = '{32'hFFFF8001, 32'h00008001, 32'h00001280, 32'h00001280};
`endif
        doReset();
        OutReady = 1'b1; Req0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            In0 = ins[i]; Mode0 = 2'(i);
            #1;
            nChecks++; if (Gnt0 !== 1'b1) begin nFails++; $display("[TB] FAIL mode%0d_gnt0: got %b want 1", i, Gnt0); end
            advance();
            nChecks++; if (OutData !== exps[i]) begin nFails++; $display("[TB] FAIL mode%0d_data: got %h want %h", i, OutData, exps[i]); end
        end
        Req0 = 1'b0;
    endtask

    task automatic test_alternation();
        doReset();
        Req0 = 1'b1; Req1 = 1'b1; OutReady = 1'b1;
        In0 = 16'(($urandom)); In1 = 16'(($urandom)); Mode0 = 2'b01; Mode1 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            nChecks++;
            if ({Gnt1, Gnt0} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                nFails++; $display("[TB] FAIL alt%0d_grants: got %b want %b", i, {Gnt1, Gnt0}, (i % 2 == 1) ? 2'b10 : 2'b01);
            end
            if (i > 0) begin
                nChecks++; if (OutId !== 1'((i - 1) % 2)) begin nFails++; $display("[TB] FAIL alt%0d_id: got %b want %0d", i, OutId, (i - 1) % 2); end
            end
            advance();
        end
        nChecks++; if (OutId !== 1'b1) begin nFails++; $display("[TB] FAIL alt_last_id: got %b want 1", OutId); end
        nChecks++; if (OutData !== {16'h0, In1}) begin nFails++; $display("[TB] FAIL alt_last_data: got %h want %h", OutData, {16'h0, In1}); end
        Req0 = 1'b0; Req1 = 1'b0;
    endtask

    task automatic test_backpressure();
        doReset();
        OutReady = 1'b1; Req0 = 1'b1; In0 = 16'h8001; Mode0 = 2'b00;
        #1;
        advance();
        Req0 = 1'b0; OutReady = 1'b0; Req1 = 1'b1;
        In1 = 16'(($urandom)); Mode1 = 2'(($urandom));
        for (int i = 0; i < 3; i++) begin
            #1;
            nChecks++; if (Gnt1 !== 1'b0) begin nFails++; $display("[TB] FAIL bp%0d_gnt1: got %b want 0", i, Gnt1); end
            advance();
            nChecks++; if (OutData !== 32'hFFFF8001) begin nFails++; $display("[TB] FAIL bp%0d_data: got %h want FFFF8001", i, OutData); end
            nChecks++; if (OutValid !== 1'b1) begin nFails++; $display("[TB] FAIL bp%0d_valid: got %b want 1", i, OutValid); end
        end
        OutReady = 1'b1;
        #1;
        nChecks++; if (Gnt1 !== 1'b1) begin nFails++; $display("[TB] FAIL bp_release_gnt1: got %b want 1", Gnt1); end
        advance();
        nChecks++; if (OutData !== extModel(In1, Mode1)) begin nFails++; $display("[TB] FAIL bp_new_data: got %h want %h", OutData, extModel(In1, Mode1)); end
        nChecks++; if (OutId !== 1'b1) begin nFails++; $display("[TB] FAIL bp_new_id: got %b want 1", OutId); end
        Req1 = 1'b0;
    endtask

    task automatic test_drain();
        doReset();
        OutReady = 1'b1; Req0 = 1'b1; In0 = 16'(($urandom)); Mode0 = 2'b01;
        #1;
        advance();
        Req0 = 1'b0;
        nChecks++; if (OutValid !== 1'b1) begin nFails++; $display("[TB] FAIL drain_full: got %b want 1", OutValid); end
        #1;
        advance();
        nChecks++; if (OutValid !== 1'b0) begin nFails++; $display("[TB] FAIL drain_empty: got %b want 0", OutValid); end
        advance();
        nChecks++; if (OutValid !== 1'b0) begin nFails++; $display("[TB] FAIL drain_stay_empty: got %b want 0", OutValid); end
    endtask

    task automatic test_reset_mid();
        doReset();
        OutReady = 1'b0; Req0 = 1'b1; In0 = 16'h8001; Mode0 = 2'b00;
        #1;
        advance();
        nChecks++; if (OutData !== 32'hFFFF8001) begin nFails++; $display("[TB] FAIL mid_loaded: got %h want FFFF8001", OutData); end
        #2;
        Reset = 1'b0;
        #1;
        nChecks++; if (OutValid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_valid: got %b want 0", OutValid); end
        nChecks++; if (OutData !== 32'h0) begin nFails++; $display("[TB] FAIL mid_data: got %h want 00000000", OutData); end
        nChecks++; if (Gnt0 !== 1'b0) begin nFails++; $display("[TB] FAIL mid_gnt0: got %b want 0", Gnt0); end
        modelReset();
        @(posedge Clk); #1;
        Reset = 1'b1; Req0 = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] expG;
        logic [1:0] lastG;
        doReset();
        lastG = 2'b00;
        for (int i = 0; i < 300; i++) begin
            nChecks++; if (OutValid !== mValid) begin nFails++; $display("[TB] FAIL rnd%0d_valid: got %b want %b", i, OutValid, mValid); end
            nChecks++; if (OutData !== mData) begin nFails++; $display("[TB] FAIL rnd%0d_data: got %h want %h", i, OutData, mData); end
            nChecks++; if (OutId !== mId) begin nFails++; $display("[TB] FAIL rnd%0d_id: got %b want %b", i, OutId, mId); end
            // Requesters keep their operand until it has been granted.
            if (!Req0 || lastG[0]) begin
                Req0 = 1'(($urandom_range(0, 1))); In0 = 16'(($urandom)); Mode0 = 2'(($urandom));
            end
            if (!Req1 || lastG[1]) begin
                Req1 = 1'(($urandom_range(0, 1))); In1 = 16'(($urandom)); Mode1 = 2'(($urandom));
            end
            OutReady = ($urandom_range(0, 3) != 0);
            #1;
            expG = modelGrants();
            nChecks++; if ({Gnt1, Gnt0} !== expG) begin nFails++; $display("[TB] FAIL rnd%0d_grants: got %b want %b", i, {Gnt1, Gnt0}, expG); end
            lastG = expG;
            advance();
        end
        Req0 = 1'b0; Req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_alternation();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ext_arbiter.md
# ext_arbiter

Shared immediate/load-data extension unit with a two-requester round-robin arbiter and a one-entry registered output. Requester 0 is the decode stage, which extends 16-bit immediates. Requester 1 is the memory stage, which extends lb/lbu/lh/lhu load data. A single extension datapath serves both stages, and each result is tagged with the requester that issued it.

## Interface

Parameters:
- none

Ports:
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-low reset (asserted when 0).
- `Req0` in 1: requester 0 has a valid operand.
- `In0` in 16: requester 0 operand.
- `Mode0` in 2: requester 0 mode. 00 = sign16, 01 = zero16, 10 = sign8, 11 = zero8.
- `Gnt0` out 1: requester 0 operand accepted this cycle (combinational).
- `Req1`, `In1`, `Mode1`, `Gnt1`: same as the four requester 0 ports, for requester 1.
- `OutValid` out 1: `OutData` holds a result.
- `OutData` out 32: extended result.
- `OutId` out 1: requester that issued the held result.
- `OutReady` in 1: consumer takes the result this cycle.

## Operation

- **Output register state:** EMPTY (`OutValid`=0) or FULL (`OutValid`=1).
- **Accept condition:** `Accept` = (EMPTY or `OutReady`) and (`Req0` or `Req1`).
- **Round-robin arbitration:**
  - `Last` holds the most recently granted requester.
  - If only one requester is requesting, it is chosen.
  - If both are requesting, the requester other than `Last` is chosen.
  - `Gnt0`/`Gnt1` = chosen and `Accept`. At most one is high.
- **On an accepting edge:**
  - `OutData` is loaded with the extension of the chosen operand.
  - `OutId` is loaded with the chosen requester.
  - `OutValid` is set to 1.
  - `Last` is set to the chosen requester.
- **On a non-accepting edge:** if FULL and `OutReady`, `OutValid` is cleared to 0 and `OutData`/`OutId` hold their values. Otherwise all state holds.
- **Extension rules (sign8/zero8 use `In[7:0]` only; `In[15:8]` is ignored):**
  - sign16: {16{In[15]}, In[15:0]}
  - zero16: {16'h0, In[15:0]}
  - sign8: {24{In[7]}, In[7:0]}
  - zero8: {24'h0, In[7:0]}
- **Backpressure:** FULL with `OutReady`=0 means both grants are 0 and `OutData`/`OutId` are stable. Requesters hold `Req`/`In`/`Mode` until granted.
- **Reset values** (asynchronous, any time including mid-transfer):
  - `OutValid`=0, `OutData`=32'h0, `OutId`=0
  - `Last`=1, so requester 0 wins the first tie.
  - An in-flight result is discarded.
  - `Gnt0`/`Gnt1` are 0 while reset is asserted.

## Timing

- **Latency:** 1 cycle. An operand granted at edge N appears on `OutData` with `OutValid`=1 after edge N.
- **Throughput:** 1 result per cycle while `OutReady`=1. Same-cycle drain and refill is allowed: FULL plus `OutReady` plus a request means a new accept with no bubble.
- **Grant path:** grants depend combinationally on `Req*`, `OutValid`, `OutReady` and `Last`. There is no combinational path from `In*`/`Mode*` to any output.
- **Simultaneous requests:** the two requesters alternate each accepted cycle. Neither requester waits more than one accepted transfer.
- **Reset release:** the first edge with `Reset`=1 may accept.

## Configuration

- Macro `EXT_BYTE_EN`.
- **Defined:** the byte modes 10/11 behave as listed under Operation.
- **Not defined:**
  - `Mode[1]` is ignored, so 10 acts as sign16 and 11 acts as zero16.
  - The 8-bit extension logic is not synthesized.

## Test plan

- **Reset:** drive `Reset`=0 with `Req0`=1 → `OutValid`=0, `OutData`=0, `OutId`=0 and `Gnt0`=0. Release reset → `Gnt0`=1 on the first cycle.
- **Mode coverage:** `Req0`, `In0`=16'h8001, modes 00/01 → `OutData`=32'hFFFF8001, then 32'h00008001. With `EXT_BYTE_EN`, `In0`=16'h1280, modes 10/11 → 32'hFFFFFF80, then 32'h00000080. Without the macro, mode 10 → 32'h00001280.
- **Tie-break and alternation:** both requesters held, `OutReady`=1, after reset → grants 0,1,0,1 on consecutive cycles. `OutId` sequence is 0,1,0,1, each with a 1-cycle lag.
- **Backpressure:** FULL with `OutReady`=0 for 3 cycles while `Req1`=1 → `Gnt1`=0 throughout and `OutData` unchanged. Raise `OutReady` → `Gnt1`=1 in the same cycle and the new result appears after the next edge.
- **Drain:** a single request, then no requests, `OutReady`=1 → `OutValid` 1 for exactly one cycle, then 0.
- **Reset mid-transfer:** assert `Reset`=0 while FULL with `OutData`=32'hFFFF8001 → `OutValid`=0 and `OutData`=0 immediately, without waiting for a clock edge.
